// File: rtl/mem_stage_if.sv
// Signal bundle around the MEM stage: EX->MEM handshake and payload, data-SRAM response,
// MEM->WB handshake and bus, and forwarding information back to ID.
interface mem_stage_if;
    logic        EX_to_MEM_valid;
    logic        MEM_allow_in;
    logic [31:0] ex_pc;
    logic [4:0]  ex_dest;
    logic [31:0] ex_alu_result;
    logic        ex_gr_we;
    logic        ex_res_from_mem;
    logic [2:0]  ex_ld_op;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        WB_allow_in;
    logic        MEM_to_WB_valid;
    logic [96:0] to_WB_data;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_dest;
    logic [31:0] mem_fwd_wdata;
    logic        mem_load_pending;

    // Upstream/downstream environment side.
    modport master (
        output EX_to_MEM_valid, ex_pc, ex_dest, ex_alu_result, ex_gr_we, ex_res_from_mem,
               ex_ld_op, data_sram_data_ok, data_sram_rdata, WB_allow_in,
        input  MEM_allow_in, MEM_to_WB_valid, to_WB_data, mem_fwd_we, mem_fwd_dest,
               mem_fwd_wdata, mem_load_pending
    );

    // The MEM stage itself.
    modport slave (
        input  EX_to_MEM_valid, ex_pc, ex_dest, ex_alu_result, ex_gr_we, ex_res_from_mem,
               ex_ld_op, data_sram_data_ok, data_sram_rdata, WB_allow_in,
        output MEM_allow_in, MEM_to_WB_valid, to_WB_data, mem_fwd_we, mem_fwd_dest,
               mem_fwd_wdata, mem_load_pending
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for / buffers the load response,
// extends load data and drives the packed WB bus plus forwarding info to ID.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);

    localparam logic [2:0] LdW  = 3'd0;
    localparam logic [2:0] LdB  = 3'd1;
    localparam logic [2:0] LdH  = 3'd2;
    localparam logic [2:0] LdBu = 3'd3;
    localparam logic [2:0] LdHu = 3'd4;

    logic        mem_valid_q;
    logic [31:0] pc_q;
    logic [4:0]  dest_q;
    logic [31:0] alu_result_q;
    logic        gr_we_q;
    logic        res_from_mem_q;
    logic [2:0]  ld_op_q;
    logic        rbuf_valid_q;
    logic [31:0] rbuf_data_q;

    logic        ready_go;
    logic        to_wb_valid;
    logic        allow_in;
    logic        handoff;
    logic        capture;
    logic [31:0] raw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] final_result;

    // A load is ready once its response is either arriving now or already buffered.
    assign ready_go    = ~res_from_mem_q | rbuf_valid_q | bus.data_sram_data_ok;
    assign to_wb_valid = mem_valid_q & ready_go;
    assign allow_in    = ~mem_valid_q | (ready_go & bus.WB_allow_in);
    assign handoff     = to_wb_valid & bus.WB_allow_in;
    assign capture     = mem_valid_q & res_from_mem_q & bus.data_sram_data_ok & ~rbuf_valid_q
                         & ~bus.WB_allow_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q    <= 1'b0;
            pc_q           <= '0;
            dest_q         <= '0;
            alu_result_q   <= '0;
            gr_we_q        <= 1'b0;
            res_from_mem_q <= 1'b0;
            ld_op_q        <= '0;
            rbuf_valid_q   <= 1'b0;
            rbuf_data_q    <= '0;
        end else begin
            if (allow_in) begin
                mem_valid_q <= bus.EX_to_MEM_valid;
                if (bus.EX_to_MEM_valid) begin
                    pc_q           <= bus.ex_pc;
                    dest_q         <= bus.ex_dest;
                    alu_result_q   <= bus.ex_alu_result;
                    gr_we_q        <= bus.ex_gr_we;
                    res_from_mem_q <= bus.ex_res_from_mem;
                    ld_op_q        <= bus.ex_ld_op;
                end
            end
            if (handoff) begin
                rbuf_valid_q <= 1'b0;
            end else if (capture) begin
                rbuf_valid_q <= 1'b1;
                rbuf_data_q  <= bus.data_sram_rdata;
            end
        end
    end

    assign raw = rbuf_valid_q ? rbuf_data_q : bus.data_sram_rdata;

    always_comb begin
        byte_sel = raw[7:0];
        unique case (alu_result_q[1:0])
            2'd0: byte_sel = raw[7:0];
            2'd1: byte_sel = raw[15:8];
            2'd2: byte_sel = raw[23:16];
            2'd3: byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
    end

    assign half_sel = alu_result_q[1] ? raw[31:16] : raw[15:0];

    // Unused encodings fall back to a full word load.
    always_comb begin
        load_data = raw;
        case (ld_op_q)
            LdB:     load_data = {{24{byte_sel[7]}}, byte_sel};
            LdBu:    load_data = {24'b0, byte_sel};
            LdH:     load_data = {{16{half_sel[15]}}, half_sel};
            LdHu:    load_data = {16'b0, half_sel};
            LdW:     load_data = raw;
            default: load_data = raw;
        endcase
    end

    assign final_result = res_from_mem_q ? load_data : alu_result_q;

    assign bus.MEM_allow_in     = allow_in;
    assign bus.MEM_to_WB_valid  = to_wb_valid;
    assign bus.to_WB_data       = {pc_q, 27'b0, dest_q, final_result, gr_we_q};
    assign bus.mem_fwd_we       = mem_valid_q & gr_we_q & (dest_q != 5'd0);
    assign bus.mem_fwd_dest     = dest_q;
    assign bus.mem_fwd_wdata    = final_result;
    assign bus.mem_load_pending = mem_valid_q & res_from_mem_q & ~ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU pass-through, load extension, WB stall buffering,
// back-to-back flow, stray responses and reset during an outstanding load.
module tb_mem_stage;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mem_stage_if bus ();

    mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [96:0] obs, input logic [96:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [96:0] wb_bus(input logic [31:0] pc, input logic [4:0] dest,
                                           input logic [31:0] res, input logic we);
        return {pc, 27'b0, dest, res, we};
    endfunction

    // Advance past the next rising edge; inputs are changed right after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs are sampled mid-cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] alu,
                         input logic we, input logic is_ld, input logic [2:0] op);
        bus.EX_to_MEM_valid = 1'b1;
        bus.ex_pc           = pc;
        bus.ex_dest         = dest;
        bus.ex_alu_result   = alu;
        bus.ex_gr_we        = we;
        bus.ex_res_from_mem = is_ld;
        bus.ex_ld_op        = op;
    endtask

    // Load enters, waits 'lat' cycles without data_ok, then the response arrives with WB ready.
    task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp, input int lat);
        issue(32'h1c00_2000, 5'd7, addr, 1'b1, 1'b1, op);
        bus.WB_allow_in = 1'b1;
        step();
        bus.EX_to_MEM_valid = 1'b0;
        for (int i = 0; i < lat; i++) begin
            sample();
            check({tag, "_pending"}, 97'(bus.mem_load_pending), 97'd1);
            check({tag, "_novalid"}, 97'(bus.MEM_to_WB_valid), 97'd0);
            step();
        end
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = rdata;
        sample();
        check({tag, "_valid"}, 97'(bus.MEM_to_WB_valid), 97'd1);
        check({tag, "_result"}, 97'(bus.to_WB_data[32:1]), 97'(exp));
        check({tag, "_nopend"}, 97'(bus.mem_load_pending), 97'd0);
        step();
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'h0;
    endtask

    logic [31:0] b2b_pc  [5];
    logic [4:0]  b2b_dst [5];
    logic [31:0] b2b_alu [5];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.EX_to_MEM_valid   = 1'b0;
        bus.ex_pc             = '0;
        bus.ex_dest           = '0;
        bus.ex_alu_result     = '0;
        bus.ex_gr_we          = 1'b0;
        bus.ex_res_from_mem   = 1'b0;
        bus.ex_ld_op          = '0;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = '0;
        bus.WB_allow_in       = 1'b1;
        step();
        step();
        sample();
        check("rst_valid", 97'(bus.MEM_to_WB_valid), 97'd0);
        check("rst_data", bus.to_WB_data, 97'd0);
        check("rst_allow", 97'(bus.MEM_allow_in), 97'd1);
        check("rst_fwd_we", 97'(bus.mem_fwd_we), 97'd0);
        check("rst_pending", 97'(bus.mem_load_pending), 97'd0);
        step();
        reset = 1'b0;

        // ALU-type instruction passes through with one cycle of latency.
        issue(32'h1c00_0000, 5'd5, 32'h1234, 1'b1, 1'b0, 3'd0);
        step();
        bus.EX_to_MEM_valid = 1'b0;
        sample();
        check("add_valid", 97'(bus.MEM_to_WB_valid), 97'd1);
        check("add_data", bus.to_WB_data, wb_bus(32'h1c00_0000, 5'd5, 32'h1234, 1'b1));
        check("add_fwd_we", 97'(bus.mem_fwd_we), 97'd1);
        check("add_fwd_dest", 97'(bus.mem_fwd_dest), 97'd5);
        check("add_fwd_wdata", 97'(bus.mem_fwd_wdata), 97'h1234);
        step();
        sample();
        check("add_gone", 97'(bus.MEM_to_WB_valid), 97'd0);
        step();

        do_load("ld_b",  3'd1, 32'h0000_1001, 32'h0000_8000, 32'hFFFF_FF80, 2);
        do_load("ld_bu", 3'd3, 32'h0000_1001, 32'h0000_8000, 32'h0000_0080, 2);
        do_load("ld_hu", 3'd4, 32'h0000_1002, 32'hABCD_0000, 32'h0000_ABCD, 1);
        do_load("ld_h",  3'd2, 32'h0000_1002, 32'hABCD_0000, 32'hFFFF_ABCD, 1);
        do_load("ld_w",  3'd0, 32'h0000_1003, 32'hABCD_0000, 32'hABCD_0000, 1);
        do_load("ld_b3", 3'd1, 32'h0000_1003, 32'h7F00_0000, 32'h0000_007F, 0);

        // WB stalls while the response arrives; the buffered value must be held.
        issue(32'h1c00_3000, 5'd9, 32'h0000_2000, 1'b1, 1'b1, 3'd0);
        bus.WB_allow_in = 1'b0;
        step();
        bus.EX_to_MEM_valid   = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h55;
        sample();
        check("stall_valid0", 97'(bus.MEM_to_WB_valid), 97'd1);
        check("stall_res0", 97'(bus.to_WB_data[32:1]), 97'h55);
        check("stall_allow0", 97'(bus.MEM_allow_in), 97'd0);
        step();
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'hAA;
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) bus.WB_allow_in = 1'b1;
            sample();
            check("stall_valid", 97'(bus.MEM_to_WB_valid), 97'd1);
            check("stall_res", 97'(bus.to_WB_data[32:1]), 97'h55);
            check("stall_allow", 97'(bus.MEM_allow_in), (i == 3) ? 97'd1 : 97'd0);
            step();
        end
        sample();
        check("stall_gone", 97'(bus.MEM_to_WB_valid), 97'd0);
        step();
        // A fresh load must wait again, proving the buffer was cleared on handoff.
        do_load("post_rbuf", 3'd0, 32'h0000_3000, 32'h1357_9BDF, 32'h1357_9BDF, 1);

        // Five back-to-back ALU instructions.
        for (int i = 0; i < 5; i++) begin
            b2b_pc[i]  = 32'h1c00_4000 + 32'(i * 4);
            b2b_dst[i] = 5'(i + 10);
            b2b_alu[i] = 32'h100 + 32'(i * 17);
        end
        bus.WB_allow_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(b2b_pc[i], b2b_dst[i], b2b_alu[i], 1'b1, 1'b0, 3'd0);
            step();
            if (i == 4) bus.EX_to_MEM_valid = 1'b0;
            sample();
            check("b2b_valid", 97'(bus.MEM_to_WB_valid), 97'd1);
            check("b2b_data", bus.to_WB_data, wb_bus(b2b_pc[i], b2b_dst[i], b2b_alu[i], 1'b1));
        end
        step();
        sample();
        check("b2b_end", 97'(bus.MEM_to_WB_valid), 97'd0);

        // Stray response with an empty stage.
        step();
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'hDEAD_BEEF;
        sample();
        check("stray_valid", 97'(bus.MEM_to_WB_valid), 97'd0);
        check("stray_allow", 97'(bus.MEM_allow_in), 97'd1);
        check("stray_pend", 97'(bus.mem_load_pending), 97'd0);
        step();
        bus.data_sram_data_ok = 1'b0;
        sample();
        check("stray_hold", bus.to_WB_data, wb_bus(b2b_pc[4], b2b_dst[4], b2b_alu[4], 1'b1));
        check("stray_valid2", 97'(bus.MEM_to_WB_valid), 97'd0);

        // Reset while a load is outstanding; data_ok during the reset cycle is ignored.
        step();
        issue(32'h1c00_5000, 5'd3, 32'h0000_5000, 1'b1, 1'b1, 3'd0);
        step();
        bus.EX_to_MEM_valid = 1'b0;
        sample();
        check("rl_pending", 97'(bus.mem_load_pending), 97'd1);
        step();
        reset                 = 1'b1;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h2468_ACE0;
        step();
        reset                 = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        sample();
        check("rl_valid", 97'(bus.MEM_to_WB_valid), 97'd0);
        check("rl_data", bus.to_WB_data, 97'd0);
        check("rl_allow", 97'(bus.MEM_allow_in), 97'd1);
        check("rl_pend", 97'(bus.mem_load_pending), 97'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the in-order LoongArch CPU. It sits between EX and WB and is the sending end of the MEM→WB valid/allow-in handshake. It holds one instruction, waits for the data-SRAM response on loads, and buffers that response when WB stalls. It extracts and sign/zero-extends load data, then drives the packed WB bus `{pc, dest, final_result, gr_we}`. It also exports register-forwarding information to ID.

## Interface
Parameters: none. WB bus width is fixed at 97 bits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- EX_to_MEM_valid  in  1  EX holds a valid instruction for MEM.
- MEM_allow_in  out  1  MEM accepts an instruction from EX this cycle.
- ex_pc  in  32  instruction PC.
- ex_dest  in  5  destination register number.
- ex_alu_result  in  32  ALU result, or the effective address for loads.
- ex_gr_we  in  1  register write enable.
- ex_res_from_mem  in  1  instruction is a load.
- ex_ld_op  in  3  load type: 0 LD_W, 1 LD_B, 2 LD_H, 3 LD_BU, 4 LD_HU; 5–7 are treated as LD_W.
- data_sram_data_ok  in  1  read response valid; the request was issued by EX.
- data_sram_rdata  in  32  read data, valid when data_ok is high.
- WB_allow_in  in  1  WB accepts this cycle.
- MEM_to_WB_valid  out  1  the WB bus carries a valid instruction.
- to_WB_data  out  97  bus layout:
  - [96:65] pc
  - [64:33] {27'b0, dest}
  - [32:1] final_result
  - [0] gr_we
- mem_fwd_we  out  1  MEM_valid & gr_we & (dest != 0).
- mem_fwd_dest  out  5  dest.
- mem_fwd_wdata  out  32  final_result.
- mem_load_pending  out  1  MEM_valid & res_from_mem & ~MEM_ready_go. When high, ID must stall rather than forward.

## Operation
State:
- MEM_valid.
- Payload registers: pc, dest, alu_result, gr_we, res_from_mem, ld_op.
- rbuf_valid and rbuf_data: the response buffer.

Handshake equations:
- MEM_ready_go = ~res_from_mem | rbuf_valid | data_sram_data_ok.
- MEM_to_WB_valid = MEM_valid & MEM_ready_go.
- MEM_allow_in = ~MEM_valid | (MEM_ready_go & WB_allow_in).

Register updates:
- When MEM_allow_in is high:
  - MEM_valid <= EX_to_MEM_valid.
  - The payload registers load from the ex_* ports only when EX_to_MEM_valid is high. Otherwise they hold.
- Response capture: when MEM_valid & res_from_mem & data_ok & ~rbuf_valid & ~WB_allow_in, set rbuf_valid <= 1 and rbuf_data <= rdata.
- rbuf_valid clears when the instruction leaves (MEM_to_WB_valid & WB_allow_in). This clear takes priority over capture.
- A data_ok arriving while ~MEM_valid, while ~res_from_mem, or while rbuf_valid is ignored. Nothing is captured and no state changes.

Load extraction:
- raw = rbuf_valid ? rbuf_data : data_sram_rdata.
- a = alu_result[1:0].
- LD_W: raw, with a ignored. No alignment exception is raised.
- LD_B / LD_BU: byte raw[8a+7:8a], sign-extended for LD_B and zero-extended for LD_BU.
- LD_H / LD_HU: half raw[16a[1]+15:16a[1]], selected by a[1] only, sign- or zero-extended.
- final_result = res_from_mem ? load_data : alu_result.

Outputs and reset:
- to_WB_data is driven from registers and the load mux at all times, whether or not it is valid.
- Reset values:
  - MEM_valid = 0, rbuf_valid = 0, all payload registers = 0.
  - Hence MEM_to_WB_valid = 0, to_WB_data = 0, MEM_allow_in = 1, mem_fwd_we = 0, mem_load_pending = 0.
- Reset mid-load drops the instruction and any buffered response. A data_ok in the reset cycle is ignored.

## Timing
- Non-load: accepted at edge N, MEM_to_WB_valid is high during cycle N+1, and it is handed to WB at the end of N+1 if WB_allow_in is high. The stage adds one cycle.
- Load: MEM_to_WB_valid rises combinationally in the first cycle data_ok is high. The data path is data_ok/rdata → to_WB_data with no register stage.
- If WB stalls in that cycle, the response is captured. From the next cycle the buffered data is driven, stable, until WB accepts.
- Back-to-back: when the instruction leaves and EX_to_MEM_valid is high in the same cycle, the new instruction is loaded at the same edge with no bubble.
- Stall: while MEM_valid & ~(MEM_ready_go & WB_allow_in), the payload and to_WB_data are held unchanged. MEM_allow_in stays 0.

## Test plan
- Reset, then an ADD-type instruction with pc=0x1c000000, dest=5, alu_result=0x1234, gr_we=1, WB_allow_in=1 → one cycle later MEM_to_WB_valid=1 and to_WB_data = {0x1c000000, 0x5, 0x1234, 1}; mem_fwd_we=1.
- LD_B with alu_result=0x...1, data_ok two cycles after entry, rdata=0x0000_8000 → mem_load_pending=1 for 2 cycles; final_result=0xFFFF_FF80 in the data_ok cycle. Repeat with LD_BU → 0x0000_0080.
- LD_HU with addr[1]=1, rdata=0xABCD_0000 → 0x0000_ABCD; LD_H → 0xFFFF_ABCD; LD_W with addr=0x...3 → 0xABCD_0000.
- WB_allow_in=0 when data_ok arrives with rdata=0x55; rdata changes to 0xAA the next cycle; WB_allow_in=1 three cycles later → final_result stays 0x55 throughout; rbuf clears on handoff; MEM_allow_in=0 during the stall.
- Five back-to-back non-loads with WB_allow_in=1 → one output per cycle, in order, no bubbles. Then a stray data_ok with MEM_valid=0 → no state change.
- Assert reset while a load awaits data_ok → next cycle MEM_to_WB_valid=0, to_WB_data=0, MEM_allow_in=1.
